// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - request/writeback bundle between register file and alu_unit
interface alu_unit_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] RD1;
  logic [7:0] RD2;
  logic [3:0] dest;
  logic       busy;
  logic [7:0] ALUResult;
  logic [3:0] WA;
  logic       write_enable;
  logic       flag_z;
  logic       flag_c;

  modport slave (
    input  start, op, RD1, RD2, dest,
    output busy, ALUResult, WA, write_enable, flag_z, flag_c
  );

  modport master (
    output start, op, RD1, RD2, dest,
    input  busy, ALUResult, WA, write_enable, flag_z, flag_c
  );
endinterface

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - sequenced 8-bit ALU; single-cycle logic ops, 8-step MUL/DIV
module alu_unit (
  input  logic       clk,
  input  logic       rst,
  alu_unit_if.slave  alu
);

  typedef enum logic {IDLE, ITER} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  state_t     r_state, r_state_n;
  logic [2:0] r_cnt, r_cnt_n;
  logic       r_is_mul, r_is_mul_n;
  logic [7:0] r_b, r_b_n;
  logic [3:0] r_dest, r_dest_n;
  logic [8:0] r_hi, r_hi_n;
  logic [7:0] r_lo, r_lo_n;
  logic [7:0] r_result, r_result_n;
  logic [3:0] r_wa, r_wa_n;
  logic       r_we, r_we_n;
  logic       r_z, r_z_n;
  logic       r_c, r_c_n;

  logic [8:0] w_sum9;
  logic [8:0] w_diff9;
  logic [7:0] w_alu_res;
  logic       w_alu_c;
  logic [8:0] w_mul_add;
  logic [8:0] w_mul_hi;
  logic [7:0] w_mul_lo;
  logic [8:0] w_div_sh;
  logic [9:0] w_div_trial;
  logic       w_div_ok;
  logic [8:0] w_div_hi;
  logic [7:0] w_div_lo;
  logic [7:0] w_fin_res;
  logic       w_fin_c;

  assign w_sum9  = {1'b0, alu.RD1} + {1'b0, alu.RD2};
  assign w_diff9 = {1'b0, alu.RD1} - {1'b0, alu.RD2};

  always_comb begin
    w_alu_res = 8'h00;
    w_alu_c   = 1'b0;
    case (alu.op)
      OP_ADD: begin w_alu_res = w_sum9[7:0];  w_alu_c = w_sum9[8]; end
      OP_SUB: begin w_alu_res = w_diff9[7:0]; w_alu_c = w_diff9[8]; end
      OP_AND: w_alu_res = alu.RD1 & alu.RD2;
      OP_OR:  w_alu_res = alu.RD1 | alu.RD2;
      OP_XOR: w_alu_res = alu.RD1 ^ alu.RD2;
      OP_SHL: begin w_alu_res = {alu.RD1[6:0], 1'b0}; w_alu_c = alu.RD1[7]; end
      default: begin w_alu_res = 8'h00; w_alu_c = 1'b0; end
    endcase
  end

  // MUL: {r_hi, r_lo} is the product/multiplier pair, shifted right once per step.
  assign w_mul_add = r_lo[0] ? (r_hi + {1'b0, r_b}) : r_hi;
  assign w_mul_hi  = {1'b0, w_mul_add[8:1]};
  assign w_mul_lo  = {w_mul_add[0], r_lo[7:1]};

  // DIV: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  // A zero divisor never goes negative, so the quotient naturally saturates to FF.
  assign w_div_sh    = {r_hi[7:0], r_lo[7]};
  assign w_div_trial = {1'b0, w_div_sh} - {2'b00, r_b};
  assign w_div_ok    = ~w_div_trial[9];
  assign w_div_hi    = w_div_ok ? w_div_trial[8:0] : w_div_sh;
  assign w_div_lo    = {r_lo[6:0], w_div_ok};

  assign w_fin_res = r_is_mul ? w_mul_lo : w_div_lo;
  assign w_fin_c   = r_is_mul ? (w_mul_add[8:1] != 8'h00) : (r_b == 8'h00);

  always_comb begin
    r_state_n  = r_state;
    r_cnt_n    = r_cnt;
    r_is_mul_n = r_is_mul;
    r_b_n      = r_b;
    r_dest_n   = r_dest;
    r_hi_n     = r_hi;
    r_lo_n     = r_lo;
    r_result_n = r_result;
    r_wa_n     = r_wa;
    r_we_n     = 1'b0;
    r_z_n      = r_z;
    r_c_n      = r_c;

    if (r_state == IDLE) begin
      if (alu.start) begin
        if (alu.op == OP_MUL || alu.op == OP_DIV) begin
          r_state_n  = ITER;
          r_cnt_n    = 3'd0;
          r_is_mul_n = (alu.op == OP_MUL);
          r_b_n      = alu.RD2;
          r_dest_n   = alu.dest;
          r_hi_n     = 9'd0;
          r_lo_n     = alu.RD1;
        end else begin
          r_result_n = w_alu_res;
          r_c_n      = w_alu_c;
          r_z_n      = (w_alu_res == 8'h00);
          r_wa_n     = alu.dest;
          r_we_n     = 1'b1;
        end
      end
    end else begin
      r_hi_n = r_is_mul ? w_mul_hi : w_div_hi;
      r_lo_n = r_is_mul ? w_mul_lo : w_div_lo;
      if (r_cnt == 3'd7) begin
        r_state_n  = IDLE;
        r_result_n = w_fin_res;
        r_c_n      = w_fin_c;
        r_z_n      = (w_fin_res == 8'h00);
        r_wa_n     = r_dest;
        r_we_n     = 1'b1;
      end else begin
        r_cnt_n = r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_is_mul <= 1'b0;
      r_b      <= 8'h00;
      r_dest   <= 4'h0;
      r_hi     <= 9'd0;
      r_lo     <= 8'h00;
      r_result <= 8'h00;
      r_wa     <= 4'h0;
      r_we     <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      r_state  <= r_state_n;
      r_cnt    <= r_cnt_n;
      r_is_mul <= r_is_mul_n;
      r_b      <= r_b_n;
      r_dest   <= r_dest_n;
      r_hi     <= r_hi_n;
      r_lo     <= r_lo_n;
      r_result <= r_result_n;
      r_wa     <= r_wa_n;
      r_we     <= r_we_n;
      r_z      <= r_z_n;
      r_c      <= r_c_n;
    end
  end

  assign alu.busy         = (r_state == ITER);
  assign alu.ALUResult    = r_result;
  assign alu.WA           = r_wa;
  assign alu.write_enable = r_we;
  assign alu.flag_z       = r_z;
  assign alu.flag_c       = r_c;

endmodule
